// File: rtl/rv32_csr_file.sv
// rv32_csr_file
// Machine-mode CSR register file for an RV32 core.
//   - The read port is combinational from registered state and serves the
//     exec-stage Zicsr unit. There is no write bypass: a read of the address
//     being written in the same cycle returns the old value.
//   - The write port commits the Zicsr result at writeback. The new value is
//     visible the following cycle.
//   - Trap entry and mret update mstatus/mepc/mcause with priority
//     trap > mret > write.
// Configuration macro: RV32_CSR_COUNTERS_EN
//   Defined:   mcycle/minstret (64-bit) plus their high halves and
//              user-level read-only shadows are implemented.
//   Undefined: the counter addresses read as unimplemented, and
//              instr_retired is ignored.
// Ports:
//   clk, resetn          core clock, async active-low reset
//   rd_addr/rd_data      exec-stage CSR read (combinational)
//   rd_write_intent      instruction will write the CSR
//   rd_illegal           unimplemented address, or a write to a read-only address
//   wr_en/wr_addr/wr_data  writeback-stage commit
//   instr_retired        one instruction retired this cycle
//   trap_en/trap_pc/trap_cause  take an exception this cycle
//   mret_en              mret retiring this cycle
//   mtvec_out, mepc_out, mie_global  registered trap state for fetch/control
module rv32_csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] rd_addr,
  input  logic        rd_write_intent,
  output logic [31:0] rd_data,
  output logic        rd_illegal,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        instr_retired,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_en,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_global
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
`ifdef RV32_CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q,          mie_d;
  logic [29:0] mtvec_q,        mtvec_d;
  logic [31:0] mscratch_q,     mscratch_d;
  logic [29:0] mepc_q,         mepc_d;
  logic [31:0] mcause_q,       mcause_d;
`ifdef RV32_CSR_COUNTERS_EN
  logic [63:0] mcycle_q,       mcycle_d;
  logic [63:0] minstret_q,     minstret_d;
`endif

  logic        rd_impl;
  logic [31:0] mstatus_rd;

  // MPP is hardwired to M-mode (2'b11); only MIE and MPIE hold state.
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  always_comb begin
    rd_data = 32'd0;
    rd_impl = 1'b1;
    case (rd_addr)
      ADDR_MSTATUS:  rd_data = mstatus_rd;
      ADDR_MISA:     rd_data = MISA_VALUE;
      ADDR_MIE:      rd_data = mie_q;
      ADDR_MTVEC:    rd_data = {mtvec_q, 2'b00};
      ADDR_MSCRATCH: rd_data = mscratch_q;
      ADDR_MEPC:     rd_data = {mepc_q, 2'b00};
      ADDR_MCAUSE:   rd_data = mcause_q;
      ADDR_MIP:      rd_data = 32'd0;
      ADDR_MHARTID:  rd_data = HART_ID;
`ifdef RV32_CSR_COUNTERS_EN
      ADDR_MCYCLE,   ADDR_CYCLE:    rd_data = mcycle_q[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:   rd_data = mcycle_q[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:  rd_data = minstret_q[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: rd_data = minstret_q[63:32];
`endif
      default: begin
        rd_data = 32'd0;
        rd_impl = 1'b0;
      end
    endcase
  end

  // Address bits [11:10] == 2'b11 mark the read-only CSR space.
  assign rd_illegal = ~rd_impl | (rd_write_intent & (rd_addr[11:10] == 2'b11));

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;

    if (trap_en) begin
      mepc_d         = trap_pc[31:2];
      mcause_d       = trap_cause;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_en) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_en && (wr_addr == ADDR_MSTATUS)) begin
      mstatus_mie_d  = wr_data[3];
      mstatus_mpie_d = wr_data[7];
    end

    // mret does not touch mepc/mcause, so only a trap blocks these writes.
    if (!trap_en && wr_en && (wr_addr == ADDR_MEPC))   mepc_d   = wr_data[31:2];
    if (!trap_en && wr_en && (wr_addr == ADDR_MCAUSE)) mcause_d = wr_data;

    if (wr_en && (wr_addr == ADDR_MIE))      mie_d      = wr_data;
    if (wr_en && (wr_addr == ADDR_MTVEC))    mtvec_d    = wr_data[31:2];
    if (wr_en && (wr_addr == ADDR_MSCRATCH)) mscratch_d = wr_data;
  end

`ifdef RV32_CSR_COUNTERS_EN
  // A write to either half replaces it and suppresses that cycle's increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instr_retired};
    if (wr_en && (wr_addr == ADDR_MCYCLE))    mcycle_d   = {mcycle_q[63:32], wr_data};
    if (wr_en && (wr_addr == ADDR_MCYCLEH))   mcycle_d   = {wr_data, mcycle_q[31:0]};
    if (wr_en && (wr_addr == ADDR_MINSTRET))  minstret_d = {minstret_q[63:32], wr_data};
    if (wr_en && (wr_addr == ADDR_MINSTRETH)) minstret_d = {wr_data, minstret_q[31:0]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^trap_pc[1:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{trap_pc[1:0], instr_retired};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= MTVEC_RESET[31:2];
      mscratch_q     <= 32'd0;
      mepc_q         <= 30'd0;
      mcause_q       <= 32'd0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

  assign mtvec_out  = {mtvec_q, 2'b00};
  assign mepc_out   = {mepc_q, 2'b00};
  assign mie_global = mstatus_mie_q;

endmodule

// File: tb/tb_rv32_csr_file.sv
// Testbench for rv32_csr_file: directed scenarios with literal expectations,
// then randomized traffic. A behavioural CSR model tracks architectural
// state, and a negedge compare process checks every DUT output every cycle.
module tb_rv32_csr_file;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] rd_addr;
  logic        rd_write_intent;
  logic [31:0] rd_data;
  logic        rd_illegal;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        instr_retired;
  logic        trap_en;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret_en;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mie_global;

  rv32_csr_file #(.HART_ID(32'd0), .MTVEC_RESET(32'h0000_0103)) dut (
    .clk(clk), .resetn(resetn),
    .rd_addr(rd_addr), .rd_write_intent(rd_write_intent),
    .rd_data(rd_data), .rd_illegal(rd_illegal),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .instr_retired(instr_retired),
    .trap_en(trap_en), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_en(mret_en),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_global(mie_global)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit        m_mie, m_mpie;
  bit [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause;
  bit [63:0] m_cycle, m_instret;

  function automatic bit [32:0] m_read(input bit [11:0] a, input bit wi);
    bit [31:0] d;
    bit        known;
    d = 0;
    known = 1;
    case (a)
      12'h300: d = 32'h1800 + (m_mpie ? 32'h80 : 0) + (m_mie ? 32'h8 : 0);
      12'h301: d = 32'h4000_0100;
      12'h304: d = m_mie_reg;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h344: d = 0;
      12'hF14: d = 0;
`ifdef RV32_CSR_COUNTERS_EN
      12'hB00, 12'hC00: d = m_cycle[31:0];
      12'hB80, 12'hC80: d = m_cycle[63:32];
      12'hB02, 12'hC02: d = m_instret[31:0];
      12'hB82, 12'hC82: d = m_instret[63:32];
`endif
      default: known = 0;
    endcase
    return {(!known) || (wi && a[11:10] == 2'b11), d};
  endfunction

  task automatic m_step();
    bit cyc_wr, ins_wr;
    cyc_wr = 0;
    ins_wr = 0;
    if (trap_en) begin
      m_mepc   = trap_pc & ~32'h3;
      m_mcause = trap_cause;
      m_mpie   = m_mie;
      m_mie    = 0;
    end else if (mret_en) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end
    if (wr_en) begin
      case (wr_addr)
        12'h300: if (!trap_en && !mret_en) begin m_mie = wr_data[3]; m_mpie = wr_data[7]; end
        12'h304: m_mie_reg  = wr_data;
        12'h305: m_mtvec    = wr_data & ~32'h3;
        12'h340: m_mscratch = wr_data;
        12'h341: if (!trap_en) m_mepc   = wr_data & ~32'h3;
        12'h342: if (!trap_en) m_mcause = wr_data;
        12'hB00: begin m_cycle[31:0]    = wr_data; cyc_wr = 1; end
        12'hB80: begin m_cycle[63:32]   = wr_data; cyc_wr = 1; end
        12'hB02: begin m_instret[31:0]  = wr_data; ins_wr = 1; end
        12'hB82: begin m_instret[63:32] = wr_data; ins_wr = 1; end
        default: ;
      endcase
    end
    if (!cyc_wr) m_cycle = m_cycle + 1;
    if (!ins_wr && instr_retired) m_instret = m_instret + 1;
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 32'h0000_0100;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
    end else begin
      m_step();
    end
  end

  always @(negedge clk) begin
    bit [32:0] e;
    if (resetn === 1'b1) begin
      e = m_read(rd_addr, rd_write_intent);
      chk($sformatf("rd_data@%03h", rd_addr), rd_data, e[31:0]);
      chk($sformatf("rd_illegal@%03h", rd_addr), {31'd0, rd_illegal}, {31'd0, e[32]});
      chk("mtvec_out", mtvec_out, m_mtvec);
      chk("mepc_out", mepc_out, m_mepc);
      chk("mie_global", {31'd0, mie_global}, {31'd0, m_mie});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; instr_retired = 0;
    trap_en = 0; trap_pc = 0; trap_cause = 0; mret_en = 0; rd_write_intent = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  logic [11:0] addr_tbl [0:21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02,
                                   12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0,
                                   12'h343, 12'hF11, 12'h000, 12'h300};

  function automatic logic [11:0] pick();
    if ($urandom_range(0, 9) == 0) return 12'($urandom());
    return addr_tbl[$urandom_range(0, 21)];
  endfunction

  initial begin
    idle();
    rd_addr = 12'h305;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    rd_addr = 12'h305; @(negedge clk);
    chk("lit_mtvec_reset", rd_data, 32'h0000_0100);
    chk("lit_mtvec_out_reset", mtvec_out, 32'h0000_0100);
    cyc();
    rd_addr = 12'hF14; @(negedge clk); chk("lit_mhartid", rd_data, 32'h0); cyc();
    rd_addr = 12'h301; @(negedge clk); chk("lit_misa", rd_data, 32'h4000_0100); cyc();
    rd_addr = 12'h300; @(negedge clk); chk("lit_mstatus_reset", rd_data, 32'h0000_1800); cyc();
    rd_addr = 12'h7C0; @(negedge clk); chk("lit_unimpl_illegal", {31'd0, rd_illegal}, 32'd1); cyc();

    wr(12'h340, 32'hDEAD_BEEF); rd_addr = 12'h340; @(negedge clk);
    chk("lit_no_bypass", rd_data, 32'h0); cyc();
    rd_addr = 12'h340; @(negedge clk); chk("lit_mscratch", rd_data, 32'hDEAD_BEEF); cyc();

    wr(12'h300, 32'h8); cyc();
    trap_en = 1; trap_pc = 32'h0000_1236; trap_cause = 32'd2; rd_addr = 12'h300;
    @(negedge clk); chk("lit_mstatus_mie", rd_data, 32'h0000_1808); cyc();
    rd_addr = 12'h341; @(negedge clk);
    chk("lit_trap_mepc", rd_data, 32'h0000_1234);
    chk("lit_trap_mepc_out", mepc_out, 32'h0000_1234); cyc();
    rd_addr = 12'h342; @(negedge clk); chk("lit_trap_mcause", rd_data, 32'd2); cyc();
    rd_addr = 12'h300; @(negedge clk);
    chk("lit_trap_mstatus", rd_data, 32'h0000_1880);
    chk("lit_trap_mie_global", {31'd0, mie_global}, 32'd0); cyc();
    mret_en = 1; cyc();
    rd_addr = 12'h300; @(negedge clk); chk("lit_mret_mstatus", rd_data, 32'h0000_1888); cyc();

    trap_en = 1; trap_pc = 32'h0000_5678; trap_cause = 32'd7; wr(12'h341, 32'h4); cyc();
    rd_addr = 12'h341; @(negedge clk); chk("lit_trap_beats_wr", rd_data, 32'h0000_5678); cyc();

`ifdef RV32_CSR_COUNTERS_EN
    wr(12'hB00, 32'hFFFF_FFFF); cyc();
    wr(12'hB80, 32'hFFFF_FFFF); cyc();
    rd_addr = 12'hB00; @(negedge clk); chk("lit_mcycle_ones", rd_data, 32'hFFFF_FFFF); cyc();
    rd_addr = 12'hB80; @(negedge clk); chk("lit_mcycleh_wrap", rd_data, 32'h0); cyc();
    rd_addr = 12'hC00; @(negedge clk);
    chk("lit_cycle_shadow", rd_data, 32'h1);
    chk("lit_cycle_legal", {31'd0, rd_illegal}, 32'd0); cyc();
    rd_addr = 12'hC00; rd_write_intent = 1; @(negedge clk);
    chk("lit_cycle_wi_illegal", {31'd0, rd_illegal}, 32'd1); cyc();
`else
    rd_addr = 12'hB00; @(negedge clk);
    chk("lit_mcycle_absent_data", rd_data, 32'h0);
    chk("lit_mcycle_absent_illegal", {31'd0, rd_illegal}, 32'd1); cyc();
    rd_addr = 12'hC00; rd_write_intent = 1; @(negedge clk);
    chk("lit_cycle_wi_illegal", {31'd0, rd_illegal}, 32'd1); cyc();
`endif
    rd_addr = 12'hF14; rd_write_intent = 1; @(negedge clk);
    chk("lit_mhartid_wi_illegal", {31'd0, rd_illegal}, 32'd1); cyc();

    for (int i = 0; i < 3000; i++) begin
      rd_addr         = pick();
      rd_write_intent = 1'($urandom_range(0, 1));
      wr_en           = ($urandom_range(0, 2) == 0);
      wr_addr         = pick();
      wr_data         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
      trap_en         = ($urandom_range(0, 19) == 0);
      mret_en         = ($urandom_range(0, 14) == 0);
      trap_pc         = $urandom();
      trap_cause      = $urandom();
      instr_retired   = !trap_en && ($urandom_range(0, 1) == 1);
      cyc();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32_csr_file.md
Name: rv32_csr_file

Overview:
Machine-mode CSR register file for the RV32 core. Provides the combinational CSR read value to the exec-stage Zicsr unit and commits the Zicsr result at writeback. Owns the trap/mret state updates and the cycle/instret counters. Sits between the decode/exec read path and the writeback commit path.

Parameters:
HART_ID, 0, value returned by mhartid (0xF14)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] ignored

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous, active-low reset
rd_addr  in  12  CSR address being read (exec stage)
rd_write_intent  in  1  instruction will write the CSR (all but CSRRS/CSRRC with rs1=x0)
rd_data  out  32  current CSR value, combinational
rd_illegal  out  1  unimplemented address, or write_intent to read-only (addr[11:10]==2'b11)
wr_en  in  1  commit write (writeback stage)
wr_addr  in  12  CSR address to commit
wr_data  in  32  value from Zicsr unit csr_result
instr_retired  in  1  one instruction retired this cycle
trap_en  in  1  take exception this cycle
trap_pc  in  32  PC of trapping instruction
trap_cause  in  32  mcause value
mret_en  in  1  mret retiring this cycle
mtvec_out  out  32  trap vector, {mtvec[31:2],2'b00}
mepc_out  out  32  return address for mret
mie_global  out  1  mstatus.MIE

Behaviour:
- Implemented CSRs: mstatus 0x300 (MIE b3, MPIE b7 writable; MPP [12:11] reads 2'b11; other bits read 0), misa 0x301 RO 32'h4000_0100, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits [1:0] forced 0), mcause 0x342, mip 0x344 reads 0, mhartid 0xF14.
- Counters: mcycle 0xB00/mcycleh 0xB80, minstret 0xB02/minstreth 0xB82 (64-bit), read-only shadows cycle 0xC00/0xC80, instret 0xC02/0xC82.
- Unimplemented address: rd_data=0, rd_illegal=1. Writes to it or to RO addresses are ignored.
- Reset (async, resetn=0): mstatus MIE=0, MPIE=0; mie, mscratch, mepc, mcause, mcycle, minstret = 0; mtvec=MTVEC_RESET&~3.
- Read is combinational from registered state. No write bypass: a read in the same cycle as a wr_en to the same address returns the old value. Forwarding is the pipeline's job.
- Write latency 1: the value is visible on rd_data the cycle after wr_en.
- mcycle increments every cycle. minstret increments in cycles with instr_retired=1. Both wrap 2^64-1 -> 0, including carry from the low word into the high word.
- A write to either half of a counter replaces that half. The 64-bit counter does not increment in that cycle.
- trap_en: mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
- mret_en: MIE<=MPIE, MPIE<=1.
- Priority in one cycle: trap_en > mret_en > wr_en for mstatus/mepc/mcause. A lower-priority write to the same register is dropped. wr_en to registers the trap does not touch still commits.
- instr_retired and trap_en both high: minstret still increments; the upstream pipeline must not assert both.
- Outputs mtvec_out, mepc_out and mie_global reflect registered state, so an update is visible next cycle.

Optional Feature:
RV32_CSR_COUNTERS_EN
- Defined: mcycle/minstret and their h/shadow addresses are implemented as above.
- Undefined: no counter flops. The counter addresses behave as unimplemented (rd_data=0, rd_illegal=1), and instr_retired is ignored.

Test Plan:
- Reset release, then read 0x305 with MTVEC_RESET=32'h0000_0103 -> rd_data=32'h0000_0100. Read 0xF14 with HART_ID=0 -> rd_data=0.
- wr 0x340 <= 32'hDEAD_BEEF, read 0x340 in the same cycle -> old value 0. Read next cycle -> 32'hDEAD_BEEF.
- Set MIE via wr 0x300 <= 32'h8, then trap_en with trap_pc=32'h0000_1236, cause=2 -> mepc=32'h1234, mcause=2, mstatus reads 32'h0000_1880. Then mret_en -> mstatus reads 32'h0000_1888.
- trap_en together with wr_en to 0x341 <= 32'h4 -> mepc holds the trap value, not 4.
- wr 0xB00 <= 32'hFFFF_FFFF and 0xB80 <= 32'hFFFF_FFFF, wait 1 cycle -> mcycle=0, mcycleh=0. Read 0xC00 -> matches 0xB00.
- Read 0xC00 with rd_write_intent=1 -> rd_illegal=1. With RV32_CSR_COUNTERS_EN undefined, read 0xB00 -> rd_data=0, rd_illegal=1.
